// File: rtl/aibcr3aux_red_pkg.sv
// Shared types for the aux active-redundancy shift controller: FSM states and
// the chain-select bit positions used to pick chain1/chain2 out of i_chain_sel.
package aibcr3aux_red_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } red_state_e;

    localparam int SEL_CH1 = 0;
    localparam int SEL_CH2 = 1;

endpackage

// File: rtl/aibcr3aux_red_shreg.sv
// Per-chain parallel-load shift register; presents the MSB it will hold after
// this cycle's load/shift so the caller can register it alongside its own state.
module aibcr3aux_red_shreg #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             next_msb
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    assign next_msb = data_d[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/aibcr3aux_red_shift_ctrl.sv
// Serially programs the two aux redundancy chains MSB first, generating its own
// divided shift strobe; every output is registered from the next-state decode.
module aibcr3aux_red_shift_ctrl
    import aibcr3aux_red_pkg::*;
#(
    parameter int CHAIN_LEN = 48,
    parameter int CLK_DIV   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [1:0]           i_chain_sel,
    input  logic [CHAIN_LEN-1:0] i_map1,
    input  logic [CHAIN_LEN-1:0] i_map2,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_red_clk,
    output logic                 o_actred1,
    output logic                 o_actred2,
    output logic                 o_shift_en_chain1,
    output logic                 o_shift_en_chain2,
    output logic                 o_idataselb_chain1,
    output logic                 o_idataselb_chain2,
    output logic                 o_txen1,
    output logic                 o_txen2
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

    red_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [1:0]       sel_q, sel_d;
    logic             load, shift;
    logic             next_msb1, next_msb2;

    logic busy_d, done_d, red_clk_d, actred1_d, actred2_d;
    logic shift_en1_d, shift_en2_d, dataselb1_d, dataselb2_d, txen1_d, txen2_d;
    logic active, shifting;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sel_d   = sel_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    sel_d   = i_chain_sel;
                    load    = 1'b1;
                    div_d   = '0;
                    state_d = (i_chain_sel != 2'b00) ? SETUP : DONE;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    bit_d   = BIT_LAST;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q - 1'b1;
                        shift = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (i_abort && state_q != IDLE) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            shift   = 1'b0;
        end
    end

    aibcr3aux_red_shreg #(.WIDTH(CHAIN_LEN)) u_shreg1 (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (load),
        .shift     (shift),
        .load_data (i_map1),
        .next_msb  (next_msb1)
    );

    aibcr3aux_red_shreg #(.WIDTH(CHAIN_LEN)) u_shreg2 (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (load),
        .shift     (shift),
        .load_data (i_map2),
        .next_msb  (next_msb2)
    );

    // Data holds the last bit through HOLD; unselected chains stay parked.
    always_comb begin
        active      = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        shifting    = (state_d == SETUP) || (state_d == SHIFT);
        busy_d      = active;
        done_d      = (state_d == DONE);
        red_clk_d   = (state_d == SHIFT) && (div_d >= DIV_HALF);
        txen1_d     = active && sel_d[SEL_CH1];
        txen2_d     = active && sel_d[SEL_CH2];
        dataselb1_d = !txen1_d;
        dataselb2_d = !txen2_d;
        shift_en1_d = shifting && sel_d[SEL_CH1];
        shift_en2_d = shifting && sel_d[SEL_CH2];
        actred1_d   = 1'b0;
        actred2_d   = 1'b0;
        if (sel_d[SEL_CH1]) begin
            if (state_d == SHIFT)     actred1_d = next_msb1;
            else if (state_d == HOLD) actred1_d = o_actred1;
        end
        if (sel_d[SEL_CH2]) begin
            if (state_d == SHIFT)     actred2_d = next_msb2;
            else if (state_d == HOLD) actred2_d = o_actred2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q            <= IDLE;
            div_q              <= '0;
            bit_q              <= '0;
            sel_q              <= '0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_red_clk          <= 1'b0;
            o_actred1          <= 1'b0;
            o_actred2          <= 1'b0;
            o_shift_en_chain1  <= 1'b0;
            o_shift_en_chain2  <= 1'b0;
            o_idataselb_chain1 <= 1'b1;
            o_idataselb_chain2 <= 1'b1;
            o_txen1            <= 1'b0;
            o_txen2            <= 1'b0;
        end else begin
            state_q            <= state_d;
            div_q              <= div_d;
            bit_q              <= bit_d;
            sel_q              <= sel_d;
            o_busy             <= busy_d;
            o_done             <= done_d;
            o_red_clk          <= red_clk_d;
            o_actred1          <= actred1_d;
            o_actred2          <= actred2_d;
            o_shift_en_chain1  <= shift_en1_d;
            o_shift_en_chain2  <= shift_en2_d;
            o_idataselb_chain1 <= dataselb1_d;
            o_idataselb_chain2 <= dataselb2_d;
            o_txen1            <= txen1_d;
            o_txen2            <= txen2_d;
        end
    end

endmodule
